// File: rtl/store_buffer.sv
// Posted-write store buffer between the M-stage store path and the data-memory write port.
// Retires stores in order over valid/ready and stalls loads that hit a pending store word.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               st_valid,
  input  logic [31:0]        st_addr,
  input  logic [3:0]         st_byteen,
  input  logic [31:0]        st_wdata,
  output logic               st_ready,
  input  logic               ld_valid,
  input  logic [31:0]        ld_addr,
  output logic               ld_stall,
  output logic               m_data_valid,
  input  logic               m_data_ready,
  output logic [31:0]        m_data_addr,
  output logic [3:0]         m_data_byteen,
  output logic [31:0]        m_data_wdata,
  output logic               sb_empty,
  output logic [PTR_W:0]     sb_count
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [29:0]      ent_addr  [DEPTH];
  logic [3:0]       ent_be    [DEPTH];
  logic [31:0]      ent_data  [DEPTH];
  logic [DEPTH-1:0] ent_valid;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic             hit;

  // Byte-offset bits are irrelevant at word granularity.
  logic unused_offsets;
  assign unused_offsets = ^{st_addr[1:0], ld_addr[1:0]};

  assign st_ready     = (count != FULL);
  assign m_data_valid = (count != '0);
  assign sb_empty     = (count == '0);
  assign sb_count     = count;

  // A store with no byte enables carries nothing to write, so it is dropped.
  assign push = st_valid && st_ready && (st_byteen != 4'b0000);
  assign pop  = m_data_valid && m_data_ready;

  // Pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (push) begin
        wr_ptr            <= wr_ptr + PTR_W'(1);
        ent_valid[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr            <= rd_ptr + PTR_W'(1);
        ent_valid[rd_ptr] <= 1'b0;
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Entry payload; only the valid bits need reset.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      ent_addr[wr_ptr] <= st_addr[31:2];
      ent_be[wr_ptr]   <= st_byteen;
      ent_data[wr_ptr] <= st_wdata;
    end
  end

  // Head presentation, zeroed when nothing is pending.
  always_comb begin
    m_data_addr   = 32'h0;
    m_data_byteen = 4'b0000;
    m_data_wdata  = 32'h0;
    if (m_data_valid) begin
      m_data_addr   = {ent_addr[rd_ptr], 2'b00};
      m_data_byteen = ent_be[rd_ptr];
      m_data_wdata  = ent_data[rd_ptr];
    end
  end

  // Word-granular load hazard against registered entries only.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_addr[i] == ld_addr[31:2])) begin
        hit = 1'b1;
      end
    end
    ld_stall = ld_valid && hit;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed vector table plus hand sequences
// for same-cycle store/load overlap and reset during drain.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [3:0]  st_byteen;
  logic [31:0] st_wdata;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_stall;
  logic        m_data_valid;
  logic        m_data_ready;
  logic [31:0] m_data_addr;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_wdata;
  logic        sb_empty;
  logic [2:0]  sb_count;

  int checks = 0;
  int errors = 0;

  store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_byteen(st_byteen), .st_wdata(st_wdata),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_stall(ld_stall),
    .m_data_valid(m_data_valid), .m_data_ready(m_data_ready),
    .m_data_addr(m_data_addr), .m_data_byteen(m_data_byteen), .m_data_wdata(m_data_wdata),
    .sb_empty(sb_empty), .sb_count(sb_count)
  );

  always #5 clk = ~clk;

  // Inputs applied before the edge; expectations describe outputs seen before that same edge.
  typedef struct {
    logic        rst;
    logic        sv;
    logic [31:0] sa;
    logic [3:0]  sb;
    logic [31:0] sd;
    logic        lv;
    logic [31:0] la;
    logic        mr;
    logic [2:0]  ecnt;
    logic [31:0] ea;
    logic [3:0]  eb;
    logic [31:0] ed;
    logic        estall;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic rst, logic sv, logic [31:0] sa, logic [3:0] sb,
                              logic [31:0] sd, logic lv, logic [31:0] la, logic mr,
                              logic [2:0] ecnt, logic [31:0] ea, logic [3:0] eb,
                              logic [31:0] ed, logic estall);
    vec_t v;
    v.rst = rst; v.sv = sv; v.sa = sa; v.sb = sb; v.sd = sd;
    v.lv = lv; v.la = la; v.mr = mr;
    v.ecnt = ecnt; v.ea = ea; v.eb = eb; v.ed = ed; v.estall = estall;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; st_valid = v.sv; st_addr = v.sa; st_byteen = v.sb; st_wdata = v.sd;
    ld_valid = v.lv; ld_addr = v.la; m_data_ready = v.mr;
  endtask

  task automatic chk_outputs(input int idx, input logic [2:0] cnt, input logic [31:0] ea,
                             input logic [3:0] eb, input logic [31:0] ed, input logic stall);
    chk("sb_count", idx, 32'(sb_count), 32'(cnt));
    chk("m_data_valid", idx, 32'(m_data_valid), 32'(cnt != 3'd0));
    chk("sb_empty", idx, 32'(sb_empty), 32'(cnt == 3'd0));
    chk("st_ready", idx, 32'(st_ready), 32'(cnt != 3'd4));
    chk("m_data_addr", idx, m_data_addr, ea);
    chk("m_data_byteen", idx, 32'(m_data_byteen), 32'(eb));
    chk("m_data_wdata", idx, m_data_wdata, ed);
    chk("ld_stall", idx, 32'(ld_stall), 32'(stall));
  endtask

  initial begin
    // Reset state and single push (1006 -> word 1004)
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 32'h1006, 4'b0100, 32'h00AB_0000, 0, 0, 1,   0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   1, 32'h1004, 4'b0100, 32'h00AB_0000, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0));
    // Fill to DEPTH with memory stalled, refused 5th push, in-order drain
    tv.push_back(mk(0, 1, 32'h10, 4'hF, 32'h1111_1111, 0, 0, 0,   0, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 32'h14, 4'hF, 32'h2222_2222, 0, 0, 0,   1, 32'h10, 4'hF, 32'h1111_1111, 0));
    tv.push_back(mk(0, 1, 32'h18, 4'hF, 32'h3333_3333, 0, 0, 0,   2, 32'h10, 4'hF, 32'h1111_1111, 0));
    tv.push_back(mk(0, 1, 32'h1C, 4'hF, 32'h4444_4444, 0, 0, 0,   3, 32'h10, 4'hF, 32'h1111_1111, 0));
    tv.push_back(mk(0, 1, 32'h20, 4'hF, 32'h5555_5555, 0, 0, 0,   4, 32'h10, 4'hF, 32'h1111_1111, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   4, 32'h10, 4'hF, 32'h1111_1111, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   3, 32'h14, 4'hF, 32'h2222_2222, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   2, 32'h18, 4'hF, 32'h3333_3333, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   1, 32'h1C, 4'hF, 32'h4444_4444, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
    // Wrap-around: push 3, pop 3, push 3 across the pointer wrap
    tv.push_back(mk(0, 1, 32'h100, 4'hF, 32'hA1, 0, 0, 0,   0, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 32'h104, 4'hF, 32'hA2, 0, 0, 0,   1, 32'h100, 4'hF, 32'hA1, 0));
    tv.push_back(mk(0, 1, 32'h108, 4'h3, 32'hA3, 0, 0, 0,   2, 32'h100, 4'hF, 32'hA1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   3, 32'h100, 4'hF, 32'hA1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   2, 32'h104, 4'hF, 32'hA2, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   1, 32'h108, 4'h3, 32'hA3, 0));
    tv.push_back(mk(0, 1, 32'h200, 4'hF, 32'hB1, 0, 0, 0,   0, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 32'h204, 4'hF, 32'hB2, 0, 0, 0,   1, 32'h200, 4'hF, 32'hB1, 0));
    tv.push_back(mk(0, 1, 32'h208, 4'hF, 32'hB3, 0, 0, 0,   2, 32'h200, 4'hF, 32'hB1, 0));
    // Simultaneous push/pop at count 2 holds; at count 4 push refused
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   3, 32'h200, 4'hF, 32'hB1, 0));
    tv.push_back(mk(0, 1, 32'h20C, 4'hF, 32'hB4, 0, 0, 1,   2, 32'h204, 4'hF, 32'hB2, 0));
    tv.push_back(mk(0, 1, 32'h210, 4'hF, 32'hB5, 0, 0, 0,   2, 32'h208, 4'hF, 32'hB3, 0));
    tv.push_back(mk(0, 1, 32'h214, 4'hF, 32'hB6, 0, 0, 0,   3, 32'h208, 4'hF, 32'hB3, 0));
    tv.push_back(mk(0, 1, 32'h218, 4'hF, 32'hB7, 0, 0, 1,   4, 32'h208, 4'hF, 32'hB3, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   3, 32'h20C, 4'hF, 32'hB4, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   2, 32'h210, 4'hF, 32'hB5, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   1, 32'h214, 4'hF, 32'hB6, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
    // Load hazard on word 0x2000
    tv.push_back(mk(0, 1, 32'h2000, 4'b0001, 32'hCC, 0, 0, 0,   0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 32'h2003, 0,   1, 32'h2000, 4'b0001, 32'hCC, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 32'h2004, 0,   1, 32'h2000, 4'b0001, 32'hCC, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 32'h2003, 1,   1, 32'h2000, 4'b0001, 32'hCC, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 32'h2003, 0,   0, 0, 0, 0, 0));
    // Reset with 3 pending, then stale-load and zero-byteen checks
    tv.push_back(mk(0, 1, 32'h300, 4'hF, 32'hC1, 0, 0, 0,   0, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 32'h304, 4'hF, 32'hC2, 0, 0, 0,   1, 32'h300, 4'hF, 32'hC1, 0));
    tv.push_back(mk(0, 1, 32'h308, 4'hF, 32'hC3, 0, 0, 0,   2, 32'h300, 4'hF, 32'hC1, 0));
    tv.push_back(mk(1, 0, 0, 0, 0, 1, 32'h304, 0,   3, 32'h300, 4'hF, 32'hC1, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 32'h304, 0,   0, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 32'h400, 4'h0, 32'hFF, 0, 0, 1,   0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 32'h400, 1,   0, 0, 0, 0, 0));

    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_byteen = '0; st_wdata = '0;
    ld_valid = 1'b0; ld_addr = '0; m_data_ready = 1'b0;
    repeat (2) @(posedge clk);

    foreach (tv[i]) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      chk_outputs(i, tv[i].ecnt, tv[i].ea, tv[i].eb, tv[i].ed, tv[i].estall);
    end

    // Store and load to the same word together: stall sees pre-push contents
    @(negedge clk);
    reset = 1'b0; st_valid = 1'b1; st_addr = 32'h500; st_byteen = 4'hF; st_wdata = 32'hDEAD_BEEF;
    ld_valid = 1'b1; ld_addr = 32'h500; m_data_ready = 1'b0;
    #1;
    chk("overlap_stall", 100, 32'(ld_stall), 32'd0);
    @(negedge clk);
    st_valid = 1'b0; ld_addr = 32'h502;
    #1;
    chk_outputs(101, 3'd1, 32'h500, 4'hF, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk);
    m_data_ready = 1'b1;
    #1;
    chk("stall_during_pop", 102, 32'(ld_stall), 32'd1);
    @(negedge clk);
    #1;
    chk_outputs(103, 3'd0, 32'h0, 4'h0, 32'h0, 1'b0);

    // Reset while draining abandons the head in flight
    @(negedge clk);
    ld_valid = 1'b0; m_data_ready = 1'b0;
    st_valid = 1'b1; st_addr = 32'h600; st_wdata = 32'h0000_0600;
    @(negedge clk);
    st_addr = 32'h604; st_wdata = 32'h0000_0604;
    @(negedge clk);
    st_valid = 1'b0; m_data_ready = 1'b1; reset = 1'b1;
    #1;
    chk_outputs(104, 3'd2, 32'h600, 4'hF, 32'h0000_0600, 1'b0);
    @(negedge clk);
    reset = 1'b0; ld_valid = 1'b1; ld_addr = 32'h604;
    #1;
    chk_outputs(105, 3'd0, 32'h0, 4'h0, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
